// File: rtl/cphy_tx_lane_sequencer.sv
// C-PHY master lane sequencer: walks one trio through LP -> HS -> LP bursts.
// It inserts the preamble, sync and post symbols and encodes 3-bit symbols into wire states.
// Each cycle computes one "emission" (LP levels or an HS wire state) that is registered onto the
// lane outputs. As a result, the outputs trail the state register by one cycle.
module cphy_tx_lane_sequencer #(
    parameter int unsigned T_LPX    = 8,
    parameter int unsigned T_PREP   = 8,
    parameter int unsigned PRE_LEN  = 14,
    parameter int unsigned POST_LEN = 7,
    parameter int unsigned T_EXIT   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_req_hs,
    input  logic [2:0] sym_data,
    input  logic       sym_valid,
    input  logic       sym_last,
    output logic       sym_ready,
    output logic [1:0] A_PU_PD,
    output logic [1:0] B_PU_PD,
    output logic [1:0] C_PU_PD,
    output logic       HsTxEn,
    output logic [2:0] LpTx,
    output logic       LpTxEn,
    output logic       tx_busy,
    output logic       underflow
);

    typedef enum logic [2:0] {
        StStop, StLpx, StPrep, StPre, StSync, StData, StPost, StExit
    } state_e;

    // Wire state is {axis[1:0], pol}; axis x=0 y=1 z=2, pol 0 means '+'.
    localparam logic [2:0] WirePlusX = 3'b000;
    localparam logic [2:0] SymPre    = 3'd3;
    localparam logic [2:0] SymFill   = 3'd4;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pre_first_q, pre_first_d;
    logic [2:0] wire_q, wire_d;

    logic [5:0] pupd_q, pupd_d;
    logic       hs_en_q, hs_en_d;
    logic       lp_en_q, lp_en_d;
    logic [2:0] lptx_q, lptx_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       uf_q, uf_d;

    logic       enc_en;
    logic [2:0] enc_sym;
    logic       hs_drive;
    logic [2:0] lp_lvl;

    // Next wire state for one symbol; sym[2] set means a pure polarity flip.
    function automatic logic [2:0] encode_f(input logic [2:0] ws, input logic [2:0] sym);
        logic [1:0] axis;
        axis = ws[2:1];
        if (sym[2]) begin
            return {axis, ~ws[0]};
        end
        if (sym[1]) begin
            axis = (axis == 2'd2) ? 2'd0 : axis + 2'd1;
        end else begin
            axis = (axis == 2'd0) ? 2'd2 : axis - 2'd1;
        end
        return {axis, ws[0] ^ sym[0]};
    endfunction

    // Wire state to {A,B,C} drive levels (H=10 L=01 M=11).
    function automatic logic [5:0] drive_f(input logic [2:0] ws);
        case (ws)
            3'b000:  return 6'b10_01_11;  // +x
            3'b001:  return 6'b01_10_11;  // -x
            3'b010:  return 6'b11_10_01;  // +y
            3'b011:  return 6'b11_01_10;  // -y
            3'b100:  return 6'b01_11_10;  // +z
            3'b101:  return 6'b10_11_01;  // -z
            default: return 6'b00_00_00;
        endcase
    endfunction

    // Next-state, counter, wire encoder and the emission for this cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pre_first_d = 1'b0;
        wire_d      = wire_q;
        enc_en      = 1'b0;
        enc_sym     = SymFill;
        hs_drive    = 1'b0;
        lp_lvl      = 3'b111;
        uf_d        = 1'b0;

        case (state_q)
            StStop: begin
                if (tx_req_hs) begin
                    state_d = StLpx;
                    cnt_d   = 8'(T_LPX - 1);
                end
            end
            StLpx: begin
                if (!tx_req_hs) begin
                    state_d = StStop;
                end else begin
                    lp_lvl = 3'b001;
                    if (cnt_q == 8'd0) begin
                        state_d = StPrep;
                        cnt_d   = 8'(T_PREP - 1);
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            StPrep: begin
                if (!tx_req_hs) begin
                    state_d = StStop;
                end else begin
                    lp_lvl = 3'b000;
                    if (cnt_q == 8'd0) begin
                        state_d     = StPre;
                        cnt_d       = 8'(PRE_LEN - 1);
                        pre_first_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            StPre: begin
                hs_drive = 1'b1;
                // The first PRE cycle only presents +x; the counter waits for it.
                if (pre_first_q) begin
                    wire_d = WirePlusX;
                end else begin
                    enc_en  = 1'b1;
                    enc_sym = SymPre;
                    if (cnt_q == 8'd0) begin
                        state_d = StSync;
                        cnt_d   = 8'd6;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            StSync: begin
                hs_drive = 1'b1;
                enc_en   = 1'b1;
                // Sync word 3,4,4,4,4,4,3 indexed by the down-count 6..0.
                enc_sym  = (cnt_q[2:0] == 3'd6 || cnt_q[2:0] == 3'd0) ? 3'd3 : 3'd4;
                if (cnt_q == 8'd0) begin
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StData: begin
                hs_drive = 1'b1;
                enc_en   = 1'b1;
                if (sym_valid && ready_q) begin
                    enc_sym = sym_data;
                    if (sym_last) begin
                        state_d = StPost;
                        cnt_d   = 8'(POST_LEN - 1);
                    end
                end else begin
                    // Starved: keep the burst alive with a filler flip.
                    uf_d = 1'b1;
                end
            end
            StPost: begin
                hs_drive = 1'b1;
                enc_en   = 1'b1;
                if (cnt_q == 8'd0) begin
                    state_d = StExit;
                    cnt_d   = 8'(T_EXIT - 1);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StExit: begin
                if (cnt_q == 8'd0) begin
                    state_d = StStop;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = StStop;
            end
        endcase

        if (enc_en) begin
            wire_d = encode_f(wire_q, enc_sym);
        end

        // HS and LP enables come from the same bit, so they can never overlap.
        hs_en_d = hs_drive;
        lp_en_d = ~hs_drive;
        lptx_d  = hs_drive ? 3'b000 : lp_lvl;
        pupd_d  = hs_drive ? drive_f(wire_d) : 6'b00_00_00;
        busy_d  = (state_q != StStop);
        // Ready tracks the state itself so acceptance and ready line up in the same cycle.
        ready_d = (state_d == StData);
    end

    // State, counter and wire-state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StStop;
            cnt_q       <= 8'd0;
            pre_first_q <= 1'b0;
            wire_q      <= WirePlusX;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pre_first_q <= pre_first_d;
            wire_q      <= wire_d;
        end
    end

    // Registered lane outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pupd_q  <= 6'b00_00_00;
            hs_en_q <= 1'b0;
            lp_en_q <= 1'b1;
            lptx_q  <= 3'b111;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            pupd_q  <= pupd_d;
            hs_en_q <= hs_en_d;
            lp_en_q <= lp_en_d;
            lptx_q  <= lptx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            uf_q    <= uf_d;
        end
    end

    assign A_PU_PD   = pupd_q[5:4];
    assign B_PU_PD   = pupd_q[3:2];
    assign C_PU_PD   = pupd_q[1:0];
    assign HsTxEn    = hs_en_q;
    assign LpTxEn    = lp_en_q;
    assign LpTx      = lptx_q;
    assign sym_ready = ready_q;
    assign tx_busy   = busy_q;
    assign underflow = uf_q;

endmodule
